// File: rtl/argmax_classifier.sv
// argmax_classifier
// Output-layer classifier: a rising edge on done opens a frame, the block then
// takes N_CLASSES scores on a valid/ready stream and reports the index and
// value of the largest one alongside a single-cycle finished pulse.
module argmax_classifier #(
    parameter int WIDTH     = 16,
    parameter int N_CLASSES = 10,
    parameter int IDX_W     = 4,
    parameter bit SIGNED    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             done,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             finished,
    output logic [IDX_W-1:0] class_idx,
    output logic [WIDTH-1:0] max_val,
    output logic             busy,
    output logic             error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } state_t;

    // Index of the final beat of a frame.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

    state_t           state_q, state_d;
    logic             prev_done_q, prev_done_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] run_max_q, run_max_d;
    logic [IDX_W-1:0] run_idx_q, run_idx_d;
    logic [IDX_W-1:0] class_idx_q, class_idx_d;
    logic [WIDTH-1:0] max_val_q, max_val_d;
    logic             error_q, error_d;

    logic             rise;
    logic             accept;
    logic             greater;
    logic             take;
    logic [WIDTH-1:0] new_max;
    logic [IDX_W-1:0] new_idx;

    // Score comparison against the running maximum, signed or unsigned.
    always_comb begin
        greater = 1'b0;
        if (SIGNED) begin
            greater = $signed(in_data) > $signed(run_max_q);
        end else begin
            greater = in_data > run_max_q;
        end
    end

    // Next-state, running max tracking, result capture and error flagging.
    always_comb begin
        state_d     = state_q;
        prev_done_d = done;
        count_d     = count_q;
        run_max_d   = run_max_q;
        run_idx_d   = run_idx_q;
        class_idx_d = class_idx_q;
        max_val_d   = max_val_q;
        error_d     = error_q;

        rise    = done & ~prev_done_q;
        accept  = in_valid && (state_q == COLLECT);
        // Beat 0 always loads; later beats only on strictly greater, so ties keep the lower index.
        take    = (count_q == '0) || greater;
        new_max = take ? in_data : run_max_q;
        new_idx = take ? count_q : run_idx_q;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = COLLECT;
                    count_d = '0;
                end
            end
            COLLECT: begin
                if (accept) begin
                    run_max_d = new_max;
                    run_idx_d = new_idx;
                    if (count_q == LAST_IDX) begin
                        state_d     = REPORT;
                        class_idx_d = new_idx;
                        max_val_d   = new_max;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new frame request while one is still in flight is dropped but remembered.
        if (rise && (state_q != IDLE)) begin
            error_d = 1'b1;
        end
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            prev_done_q <= 1'b0;
            count_q     <= '0;
            run_max_q   <= '0;
            run_idx_q   <= '0;
            class_idx_q <= '0;
            max_val_q   <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_done_q <= prev_done_d;
            count_q     <= count_d;
            run_max_q   <= run_max_d;
            run_idx_q   <= run_idx_d;
            class_idx_q <= class_idx_d;
            max_val_q   <= max_val_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = (state_q == COLLECT);
    assign finished  = (state_q == REPORT);
    assign busy      = (state_q != IDLE);
    assign class_idx = class_idx_q;
    assign max_val   = max_val_q;
    assign error     = error_q;

endmodule
